// File: rtl/matrix_scan_capture_pkg.sv
// Shared definitions for the LED-matrix scan capture block.
// Latency: n/a (types, constants and the frame bit mapping only).
// Backpressure: n/a.
package matrix_scan_capture_pkg;

    localparam int NUM_COL  = 5;
    localparam int NUM_LINE = 7;
    localparam int FRAME_W  = NUM_COL * NUM_LINE;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } scan_state_t;

    typedef logic [NUM_LINE-1:0] col_dat_t;

    // Frame bit for (line, column), identical to the display driver's layout:
    // line 6 / column 0 lands on the MSB, line 0 / column 4 on bit 0.
    function automatic int frame_bit(input int line, input int col);
        return NUM_COL * line + (NUM_COL - 1) - col;
    endfunction

endpackage

// File: rtl/matrix_scan_capture_filter.sv
// Deglitches the column strobes and emits one accept per stable strobe episode.
// Latency: combinational accept on the sample_en edge whose sample completes the run.
// Backpressure: none; sample_en paces everything and accepts cannot be stalled.
//
// Ports: clk/clr (async active-low), sample_en strobe, col_in strobes,
//        acc_vld accept event, acc_invalid (more than one bit set), acc_col index.
module scan_strobe_filter #(
    parameter int STABLE_SAMPLES = 2,
    parameter int NUM_COL        = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               sample_en,
    input  logic [NUM_COL-1:0] col_in,
    output logic               acc_vld,
    output logic               acc_invalid,
    output logic [2:0]         acc_col
);

    localparam logic [3:0] STABLE_W = 4'(STABLE_SAMPLES);

    logic [NUM_COL-1:0] col_q;
    logic [3:0]         run_q;
    logic [3:0]         run_d;
    logic               same;
    logic [2:0]         n_set;

    assign same = (col_in == col_q);

    // Run saturates at the threshold so a long-held strobe cannot fire twice.
    always_comb begin
        run_d = 4'd1;
        if (same) begin
            run_d = (run_q == STABLE_W) ? run_q : run_q + 4'd1;
        end
    end

    // Fire only on the sample that first reaches the threshold; blanking never fires.
    assign acc_vld = sample_en && (col_in != '0) && (run_d == STABLE_W)
                     && !(same && (run_q == STABLE_W));

    // Bit 4 is column 0, so the index is mirrored.
    always_comb begin
        acc_col = '0;
        n_set   = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            if (col_in[i]) begin
                acc_col = 3'(NUM_COL - 1 - i);
                n_set   = n_set + 3'd1;
            end
        end
    end

    assign acc_invalid = (n_set > 3'd1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            col_q <= '0;
            run_q <= '0;
        end else if (sample_en) begin
            col_q <= col_in;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds the 7x5 LED-matrix frame from observed column strobes and line data.
// Latency: frame_valid rises 1 clk after the sample_en edge that accepts column 4.
// Backpressure: none; frames are published as pulses and overwrite frame_out.
//
// Ports: clk, clr (async active-low), sample_en, col_in[4:0] (bit 4 = column 0),
//        line_in[6:0]; frame_out[34:0], frame_valid, frame_changed, locked,
//        seq_err, frame_cnt[7:0].
module matrix_scan_capture #(
    parameter int STABLE_SAMPLES  = 2,
    parameter int TIMEOUT_SAMPLES = 255,
    parameter int NUM_COL         = 5,
    parameter int NUM_LINE        = 7
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         sample_en,
    input  logic [NUM_COL-1:0]           col_in,
    input  logic [NUM_LINE-1:0]          line_in,
    output logic [NUM_COL*NUM_LINE-1:0]  frame_out,
    output logic                         frame_valid,
    output logic                         frame_changed,
    output logic                         locked,
    output logic                         seq_err,
    output logic [7:0]                   frame_cnt
);

    import matrix_scan_capture_pkg::*;

    localparam int         FW      = NUM_COL * NUM_LINE;
    localparam logic [11:0] TMO_MAX = 12'(TIMEOUT_SAMPLES);
    localparam logic [2:0]  LAST_COL = 3'(NUM_COL - 1);

    scan_state_t state_q, state_d;
    logic [2:0]  exp_col_q, exp_col_d;
    logic [NUM_COL-1:0][NUM_LINE-1:0] shadow_q;
    logic [11:0] tmo_q;
    logic [FW-1:0] pub_frame;

    logic       acc_vld;
    logic       acc_invalid;
    logic [2:0] acc_col;

    logic wr_en;
    logic publish;
    logic err;
    logic lose;
    logic tmo_hit;

    scan_strobe_filter #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .NUM_COL        (NUM_COL)
    ) u_filter (
        .clk         (clk),
        .clr         (clr),
        .sample_en   (sample_en),
        .col_in      (col_in),
        .acc_vld     (acc_vld),
        .acc_invalid (acc_invalid),
        .acc_col     (acc_col)
    );

    // Frame as it would be published now: columns 0..3 from the shadow,
    // column 4 straight from line_in so the publish happens on the accept edge.
    always_comb begin
        pub_frame = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            for (int r = 0; r < NUM_LINE; r++) begin
                if (c == NUM_COL - 1) begin
                    pub_frame[6'(frame_bit(r, c))] = line_in[3'(r)];
                end else begin
                    pub_frame[6'(frame_bit(r, c))] = shadow_q[3'(c)][3'(r)];
                end
            end
        end
    end

    // Timeout fires on the tick that brings the idle count up to the limit;
    // an accept on the same tick takes priority.
    assign tmo_hit = sample_en && !acc_vld && (tmo_q == TMO_MAX - 12'd1);

    always_comb begin
        state_d   = state_q;
        exp_col_d = exp_col_q;
        wr_en     = 1'b0;
        publish   = 1'b0;
        err       = 1'b0;
        lose      = 1'b0;
        case (state_q)
            HUNT: begin
                // Only a clean column 0 starts tracking; anything else is silent.
                if (acc_vld && !acc_invalid && (acc_col == 3'd0)) begin
                    wr_en     = 1'b1;
                    exp_col_d = 3'd1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (acc_vld) begin
                    if (acc_invalid || (acc_col != exp_col_q)) begin
                        err     = 1'b1;
                        state_d = HUNT;
                    end else begin
                        wr_en = 1'b1;
                        if (acc_col == LAST_COL) begin
                            publish   = 1'b1;
                            exp_col_d = 3'd0;
                        end else begin
                            exp_col_d = exp_col_q + 3'd1;
                        end
                    end
                end else if (tmo_hit) begin
                    lose    = 1'b1;
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= HUNT;
            exp_col_q     <= '0;
            shadow_q      <= '0;
            tmo_q         <= '0;
            frame_out     <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            locked        <= 1'b0;
            seq_err       <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            state_q       <= state_d;
            exp_col_q     <= exp_col_d;
            frame_valid   <= publish;
            frame_changed <= publish && (pub_frame != frame_out);
            seq_err       <= err;

            if (wr_en) begin
                shadow_q[acc_col] <= line_in;
            end

            if (publish) begin
                frame_out <= pub_frame;
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (publish) begin
                locked <= 1'b1;
            end else if (err || lose) begin
                locked <= 1'b0;
            end

            if (acc_vld) begin
                tmo_q <= '0;
            end else if (sample_en && (tmo_q != TMO_MAX)) begin
                tmo_q <= tmo_q + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Scoreboard bench for matrix_scan_capture: expected frames are queued as
// column 4 is driven and popped when frame_valid is observed.
module tb_matrix_scan_capture;

    localparam int STABLE = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        sample_en = 1'b0;
    logic [4:0]  col_in = '0;
    logic [6:0]  line_in = '0;
    logic [34:0] frame_out;
    logic        frame_valid;
    logic        frame_changed;
    logic        locked;
    logic        seq_err;
    logic [7:0]  frame_cnt;

    typedef struct {
        logic [34:0] frame;
        logic        changed;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        none_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          seq_err_seen = 0;
    int          exp_seq_err = 0;
    logic [34:0] model_frame = '0;
    logic [7:0]  model_cnt = '0;

    matrix_scan_capture #(
        .STABLE_SAMPLES  (STABLE),
        .TIMEOUT_SAMPLES (255),
        .NUM_COL         (5),
        .NUM_LINE        (7)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .sample_en     (sample_en),
        .col_in        (col_in),
        .line_in       (line_in),
        .frame_out     (frame_out),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .locked        (locked),
        .seq_err       (seq_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every published frame.
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            if (seq_err) seq_err_seen++;
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_frame_valid", frame_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_out", frame_out, e.frame);
                    check("frame_changed", frame_changed, e.changed);
                    check("frame_cnt", frame_cnt, e.cnt);
                    check("valid_latency_cyc", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] onehot(input int c);
        logic [4:0] v;
        v = 5'b10000;
        return v >> c;
    endfunction

    function automatic logic [6:0] col_lines(input logic [34:0] f, input int c);
        logic [6:0] v;
        for (int r = 0; r < 7; r++) v[r] = f[5 * r + 4 - c];
        return v;
    endfunction

    // One sample_en pulse followed by an idle cycle.
    task automatic sample(input logic [4:0] c, input logic [6:0] l, input bit pub, input exp_t e);
        exp_t ee;
        @(negedge clk);
        col_in    = c;
        line_in   = l;
        sample_en = 1'b1;
        if (pub) begin
            ee     = e;
            ee.cyc = cyc + 1;
            exp_q.push_back(ee);
        end
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic scan_col(input int c, input logic [6:0] l, input int hold, input bit pub, input exp_t e);
        for (int h = 0; h < hold; h++) sample(onehot(c), l, pub && (h == STABLE - 1), e);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) sample(5'b0, 7'h7f, 1'b0, none_e);
    endtask

    // Full column 0..4 scan; expected frame queued on the column-4 accept.
    task automatic scan_frame(input logic [34:0] f, input int hold, input bit gaps, input bit glitch);
        exp_t e;
        e.frame   = f;
        e.changed = (f != model_frame);
        e.cnt     = model_cnt + 8'd1;
        e.cyc     = 0;
        model_frame = f;
        model_cnt   = model_cnt + 8'd1;
        for (int c = 0; c < 5; c++) begin
            scan_col(c, col_lines(f, c), hold, c == 4, e);
            if (glitch && c == 0) sample(onehot(3), 7'h55, 1'b0, none_e);
            if (gaps && c != 4) blank(2);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_frame_out"}, frame_out, 35'h0);
        check({tag, "_frame_valid"}, frame_valid, 1'b0);
        check({tag, "_frame_changed"}, frame_changed, 1'b0);
        check({tag, "_locked"}, locked, 1'b0);
        check({tag, "_seq_err"}, seq_err, 1'b0);
        check({tag, "_frame_cnt"}, frame_cnt, 8'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        col_in = '0;
        #2 clr = 1'b0;
        @(negedge clk);
        check_idle("reset");
        model_frame = '0;
        model_cnt   = '0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    localparam logic [34:0] F_R0    = 35'h5_A5C3_3C96;
    localparam logic [34:0] F_PIXEL = 35'h4_0000_0000;
    localparam logic [34:0] F_B     = 35'h1_2345_6789;
    localparam logic [34:0] F_D     = 35'h7_FFFF_FFFE;
    localparam logic [34:0] F_C     = 35'h0_0F0F_F0F1;

    initial begin
        none_e = '{frame: '0, changed: 1'b0, cnt: '0, cyc: 0};

        // Reset state
        repeat (3) @(negedge clk);
        check_idle("por");
        clr = 1'b1;

        // First frame with blanking between columns
        scan_frame(F_R0, 3, 1'b1, 1'b0);
        check("r0_locked", locked, 1'b1);

        // Reset in the middle of column 2
        scan_col(0, 7'h11, 3, 1'b0, none_e);
        scan_col(1, 7'h22, 3, 1'b0, none_e);
        sample(onehot(2), 7'h33, 1'b0, none_e);
        do_reset();
        // HUNT must ignore the tail of the interrupted scan
        scan_col(3, 7'h44, 3, 1'b0, none_e);
        scan_col(4, 7'h55, 3, 1'b0, none_e);
        check("post_rst_locked", locked, 1'b0);
        check("post_rst_cnt", frame_cnt, 8'd0);

        // Single-pixel frame twice
        scan_frame(F_PIXEL, 3, 1'b0, 1'b0);
        check("pixel_locked", locked, 1'b1);
        scan_frame(F_PIXEL, 3, 1'b0, 1'b0);

        // Out-of-order 0,1,3
        scan_col(0, 7'h01, 3, 1'b0, none_e);
        scan_col(1, 7'h02, 3, 1'b0, none_e);
        scan_col(3, 7'h04, 3, 1'b0, none_e);
        exp_seq_err++;
        check("ooo_seq_err", seq_err_seen, exp_seq_err);
        check("ooo_locked", locked, 1'b0);
        check("ooo_frame_hold", frame_out, F_PIXEL);

        // Start mid-scan: columns 2,3 ignored silently in HUNT
        scan_col(2, 7'h08, 3, 1'b0, none_e);
        scan_col(3, 7'h10, 3, 1'b0, none_e);
        check("midscan_seq_err", seq_err_seen, exp_seq_err);
        check("midscan_cnt", frame_cnt, 8'd2);
        scan_frame(F_B, 3, 1'b0, 1'b0);

        // One-sample glitch after column 0 is ignored
        scan_frame(F_D, 3, 1'b0, 1'b1);
        check("glitch_seq_err", seq_err_seen, exp_seq_err);

        // Two-hot strobe in CAPTURE
        scan_col(0, 7'h7f, 3, 1'b0, none_e);
        sample(5'b10010, 7'h00, 1'b0, none_e);
        sample(5'b10010, 7'h00, 1'b0, none_e);
        exp_seq_err++;
        check("invalid_seq_err", seq_err_seen, exp_seq_err);
        check("invalid_locked", locked, 1'b0);
        check("invalid_frame_hold", frame_out, F_D);

        // Timeout: 255 idle ticks after the column-4 accept
        scan_frame(F_C, 2, 1'b0, 1'b0);
        check("tmo_pre_locked", locked, 1'b1);
        blank(254);
        check("tmo_254_locked", locked, 1'b1);
        blank(1);
        check("tmo_255_locked", locked, 1'b0);
        check("tmo_frame_hold", frame_out, F_C);
        check("tmo_seq_err", seq_err_seen, exp_seq_err);
        // Back in HUNT: columns 1..4 alone publish nothing
        for (int c = 1; c < 5; c++) scan_col(c, 7'h3c, 3, 1'b0, none_e);
        check("tmo_hunt_cnt", frame_cnt, 8'd5);

        // 256 frames wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) scan_frame(35'(i * 32'h9E37_79B1), 2, 1'b0, 1'b0);
        check("wrap_cnt", frame_cnt, 8'd0);
        check("wrap_frame", frame_out, 35'(255 * 32'h9E37_79B1));

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("final_seq_err", seq_err_seen, exp_seq_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scan_capture.md
Name: matrix_scan_capture

Overview:
- Receive-side counterpart of the LED-matrix scan driver: observes the multiplexed column strobes and line bus that drive the 7x5 matrix and rebuilds the full 35-bit frame.
- Sits beside, or remote from, the display driver. Used by the opponent board to read the attack grid and by self-check logic to confirm that the matrix shows the stored position/attack register.
- Publishes each complete frame with a valid pulse, a changed flag, a lock indicator and sequence-error reporting.

Parameters:
- STABLE_SAMPLES, 2: consecutive identical col_in samples (at sample_en) required before a column is accepted; legal range 1..15.
- TIMEOUT_SAMPLES, 255: sample_en ticks without a new accepted column before lock is lost; legal range 1..4095.
- NUM_COL, 5: matrix columns; only 5 is supported.
- NUM_LINE, 7: matrix lines; only 7 is supported.

Ports:
- clk, input, 1: system clock.
- clr, input, 1: asynchronous active-low reset.
- sample_en, input, 1: one-cycle sample strobe, driven by the frequency-divider tap.
- col_in, input, 5: column strobes, one-hot active-high. Bit 4 is column 0 (leftmost), bit 0 is column 4.
- line_in, input, 7: line data for the active column. Bit r is line r.
- frame_out, output, 35: last complete frame. Bit index = 5*r + 4 - c for line r, column c (line 6, column 0 is bit 34).
- frame_valid, output, 1: one-cycle pulse when frame_out updates.
- frame_changed, output, 1: valid alongside frame_valid; 1 when the new frame differs from the previous frame_out.
- locked, output, 1: high while a correctly ordered scan is being tracked.
- seq_err, output, 1: one-cycle pulse on an out-of-order or non-one-hot accepted column.
- frame_cnt, output, 8: count of published frames; wraps 255 to 0.

Behaviour:
- Reset (clr low, asynchronous): frame_out=0, frame_valid=0, frame_changed=0, locked=0, seq_err=0, frame_cnt=0. State goes to HUNT; shadow buffer, filter and timeout counters are cleared. Reset mid-frame discards the partial frame.
- All logic advances only on clk edges where sample_en=1. Flags are not pulsed on other cycles.
- Deglitch filter:
  - col_in is registered each sample; a run counter counts consecutive identical samples.
  - When the run reaches STABLE_SAMPLES, one accept event fires for that strobe episode. No further accept fires until col_in changes.
  - col_in=0 (blanking) never produces an accept and does not reset the expected column.
  - line_in is captured on the same sample that fires the accept.
- Accepted value classification: one-hot column index c (0..4), or INVALID (two or more bits set).
- States:
  - HUNT: wait for an accepted column 0. On it, write line_in into shadow column 0, set expected column to 1 and go to CAPTURE. Other accepted columns are ignored silently, with no seq_err.
  - CAPTURE: an accepted column equal to the expected column writes shadow column c. At c=4, a full frame is published. Expected column then wraps to 0 and the state stays CAPTURE (back-to-back frames).
  - CAPTURE error: an accepted column that does not match, or INVALID, pulses seq_err, clears locked and returns to HUNT. The shadow buffer is discarded and frame_out holds its value.
- Publish, on the clock edge after the col-4 accept:
  - frame_out is loaded from the shadow buffer, with the col-4 data merged in the same edge.
  - frame_changed = (new frame != old frame_out).
  - frame_valid=1 and frame_cnt increments.
  - locked sets on the first publish.
- Timeout: a counter increments per sample_en and clears on every accept. Reaching TIMEOUT_SAMPLES clears locked and returns to HUNT. There is no seq_err and frame_out holds.
- Simultaneous accept and timeout on the same sample: the accept wins and the counter clears.
- Latency: frame_valid asserts exactly 1 clk after the sample_en edge that accepts column 4.

Decomposition:
- Shared package holds:
  - state enum (HUNT, CAPTURE);
  - NUM_COL and NUM_LINE;
  - FRAME_W = 35;
  - the bit-index mapping function (line, column) -> frame bit, the same mapping used by the display driver.
- One sub-module, scan_strobe_filter: col_in register, run counter and accept/INVALID/column-index generation.
- The FSM, shadow buffer, publish and timeout logic live in the top.

Test Plan:
- Reset mid-frame: clr low during column 2 of the first scan -> all outputs 0 and state HUNT. The next frame is published only after a full column 0..4 sequence.
- Single-pixel frame: line 6 high on column 0 only, each column held 3 samples -> frame_out=35'h4_0000_0000, one frame_valid, frame_changed=1, frame_cnt=1, locked=1. An identical second scan gives frame_valid=1, frame_changed=0, frame_cnt=2.
- Start mid-scan: first stable strobe is column 2 -> no seq_err and no publish until column 0 arrives, followed by columns 1..4.
- Out-of-order: columns 0, 1, 3 -> seq_err pulse on the column-3 accept, locked=0, frame_out unchanged, state HUNT.
- Glitch and invalid: a one-hot strobe held 1 sample with STABLE_SAMPLES=2 -> ignored. col_in=5'b10010 stable for 2 samples in CAPTURE -> seq_err pulse.
- Timeout and wrap: strobes stopped for 255 sample_en ticks after lock -> locked=0 and no frame_valid. 256 published frames -> frame_cnt wraps to 0.
